// File: rtl/mux_src_arbiter.sv
// Round-robin arbiter for two valid/ready sources feeding a 1-entry output slice.
// Optional grant counters are built when MUX_ARB_STATS_EN is defined.
module mux_src_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic             control,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   // Slice state is carried directly by out_valid.
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             prio_q, prio_d;
   logic             ctrl_q, ctrl_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             load;
   logic             grant_a;
   logic             grant_b;

   assign load    = (state_q == EMPTY) | out_ready;
   assign grant_a = a_valid & (~b_valid | ~prio_q);
   assign grant_b = b_valid & (~a_valid |  prio_q);
   assign a_ready = ~reset & load & grant_a;
   assign b_ready = ~reset & load & grant_b;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      ctrl_d  = ctrl_q;
      out_d   = out_q;
      case (state_q)
         EMPTY: begin
            if (a_ready) begin
               state_d = FULL;
               ctrl_d  = 1'b1;
               out_d   = a_data;
               prio_d  = 1'b1;
            end else if (b_ready) begin
               state_d = FULL;
               ctrl_d  = 1'b0;
               out_d   = b_data;
               prio_d  = 1'b0;
            end else begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_ready) begin
               if (a_ready) begin
                  ctrl_d = 1'b1;
                  out_d  = a_data;
                  prio_d = 1'b1;
               end else if (b_ready) begin
                  ctrl_d = 1'b0;
                  out_d  = b_data;
                  prio_d = 1'b0;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         prio_q  <= 1'b0;
         ctrl_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         ctrl_q  <= ctrl_d;
         out_q   <= out_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign control   = ctrl_q;
   assign out       = out_q;

`ifdef MUX_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   // Counters saturate at all-ones instead of wrapping.
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (a_ready && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
      if (b_ready && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`else
   assign cnt_a = '0;
   assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Scoreboard bench for mux_src_arbiter: directed stimulus pushes expected
// {control,data} beats; a negedge monitor pops and compares consumed beats.
module tb_mux_src_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid;
   logic       a_ready, b_ready;
   logic       control;
   logic [7:0] out;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] cnt_a, cnt_b;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [8:0]  exp_q[$];

   mux_src_arbiter #(.WIDTH(8), .CNT_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .control   (control),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every beat consumed downstream must match the queue head.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat: unexpected ctrl=%0b data=%0h", control, out);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("beat", {23'd0, control, out}, {23'd0, e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, summary forced");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
      a_data = 8'h11; b_data = 8'h22; out_ready = 1'b1;

      // 1: reset with both sources valid
      @(negedge clock);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_out", out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_control", control, 0);

      // 2: A-only beat
      cyc();
      reset = 1'b0; b_valid = 1'b0; a_valid = 1'b1; a_data = 8'h3C;
      exp_q.push_back({1'b1, 8'h3C});
      @(negedge clock);
      chk("t2_a_ready", a_ready, 1);
      chk("t2_b_ready", b_ready, 0);
      cyc();
      a_valid = 1'b0;
      @(negedge clock);
      chk("t2_out_valid", out_valid, 1);
      chk("t2_b_ready_idle", b_ready, 0);

      // B-only beat moves priority back to A
      cyc();
      b_valid = 1'b1; b_data = 8'h77;
      exp_q.push_back({1'b0, 8'h77});
      @(negedge clock);
      chk("b_only_a_ready", a_ready, 0);
      chk("b_only_b_ready", b_ready, 1);

      // 3: both valid continuously -> A,B,A,B with no bubbles
      for (int i = 0; i < 4; i++) begin
         cyc();
         a_valid = 1'b1; b_valid = 1'b1;
         a_data = 8'h10 + 8'(i); b_data = 8'h20 + 8'(i);
         if (i % 2 == 0) exp_q.push_back({1'b1, 8'h10 + 8'(i)});
         else            exp_q.push_back({1'b0, 8'h20 + 8'(i)});
         @(negedge clock);
         chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
         chk("rr_no_bubble", out_valid, 1);
      end

      // 4: load A5 then stall three cycles with both valid
      cyc();
      b_valid = 1'b0; a_data = 8'hA5;
      exp_q.push_back({1'b1, 8'hA5});
      cyc();
      out_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
      a_data = 8'h55; b_data = 8'h66;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("stall_out", out, 8'hA5);
         chk("stall_control", control, 1);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_a_ready", a_ready, 0);
         chk("stall_b_ready", b_ready, 0);
         cyc();
      end

      // 5: reset while FULL drops the held beat
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out", out, 0);
      chk("midrst_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      cyc();
      reset = 1'b0; out_ready = 1'b1;
      a_data = 8'h81; b_data = 8'h82;
      exp_q.push_back({1'b1, 8'h81});
      @(negedge clock);
      chk("postrst_a_first", a_ready, 1);
      chk("postrst_b_ready", b_ready, 0);
      cyc();
      a_valid = 1'b0; b_valid = 1'b0;
      cyc();
      @(negedge clock);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_out_hold", out, 8'h81);
      chk("drain_ctrl_hold", control, 1);

      // 6: 20 back-to-back A grants
      for (int i = 0; i < 20; i++) begin
         cyc();
         a_valid = 1'b1; a_data = 8'(8'hC0 + i);
         exp_q.push_back({1'b1, 8'(8'hC0 + i)});
      end
      cyc();
      a_valid = 1'b0;
      cyc();
      cyc();
      @(negedge clock);
`ifdef MUX_ARB_STATS_EN
      chk("cnt_a_sat", cnt_a, 4'hF);
`else
      chk("cnt_a_off", cnt_a, 0);
`endif
      chk("cnt_b", cnt_b, 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
